building_grid: RTL and testbench

Parametrised building-slot manager and renderer for the island playfield. Holds one occupancy bit per building slot in two horizontal bands (top and bottom of the island). Auto-constructs one building per `BUILD_INTERVAL` game steps via a bounded round-robin search. Clears and blocks slots under a multi-level flood, and outputs a registered 12-bit pixel that is ORed into the frame compositor alongside the water and people layers.

---
 rtl/building_grid_if.sv | 34 +++
 rtl/building_grid.sv | 205 ++++++++++++++++++++
 tb/tb_building_grid.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/building_grid_if.sv
// Purpose : signal bundle between the playfield controller and building_grid.
// Macro   : none.
// Ports   : game_step, flood_level, hcount_in, vcount_in   (controller -> grid)
//           pixel_out, bldg_count, full, build_pulse, build_idx (grid -> controller)
// Modports: master drives game ticks and raster position, slave is building_grid.
interface building_grid_if #(
  parameter int unsigned SLOTS_PER_ROW = 12,
  parameter int unsigned MAX_FLOOD     = 3
);
  localparam int unsigned NUM_SLOTS = 2 * SLOTS_PER_ROW;
  localparam int unsigned FL_W      = $clog2(MAX_FLOOD + 1);
  localparam int unsigned CNT_W     = $clog2(NUM_SLOTS + 1);
  localparam int unsigned IDX_W     = $clog2(NUM_SLOTS);

  logic             game_step;
  logic [FL_W-1:0]  flood_level;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic [11:0]      pixel_out;
  logic [CNT_W-1:0] bldg_count;
  logic             full;
  logic             build_pulse;
  logic [IDX_W-1:0] build_idx;

  modport master (
    output game_step, flood_level, hcount_in, vcount_in,
    input  pixel_out, bldg_count, full, build_pulse, build_idx
  );

  modport slave (
    input  game_step, flood_level, hcount_in, vcount_in,
    output pixel_out, bldg_count, full, build_pulse, build_idx
  );
endinterface

// File: rtl/building_grid.sv
// Purpose : building-slot manager and renderer for the island playfield.
//           Two bands of SLOTS_PER_ROW slots; one build attempt every
//           BUILD_INTERVAL game steps via a bounded round-robin search;
//           flooded columns are cleared every cycle; registered 12-bit pixel.
// Macro   : BLDG_RECLAIM_EN - when defined, slots become buildable again once
//           the flood recedes; when undefined, any flooded slot is ruined
//           (permanently blocked) until reset.
// Ports   : clk_in  - pixel clock
//           rst_in  - asynchronous reset, active-low
//           bus     - building_grid_if.slave (game_step, flood_level,
//                     hcount_in, vcount_in in; pixel_out, bldg_count, full,
//                     build_pulse, build_idx out, all registered)
module building_grid #(
  parameter int unsigned SLOTS_PER_ROW  = 12,
  parameter int unsigned SLOT_W         = 64,
  parameter int unsigned SLOT_H         = 96,
  parameter int unsigned LEFT_EDGE      = 128,
  parameter int unsigned TOP_ROW_Y      = 0,
  parameter int unsigned BOTTOM_ROW_Y   = 672,
  parameter int unsigned BUILD_INTERVAL = 32,
  parameter int unsigned FLOOD_COLS     = 2,
  parameter int unsigned MAX_FLOOD      = 3,
  parameter logic [11:0] COLOR_1        = 12'hA52,
  parameter logic [11:0] COLOR_2        = 12'h652
) (
  input  logic            clk_in,
  input  logic            rst_in,
  building_grid_if.slave  bus
);
  localparam int unsigned NUM_SLOTS = 2 * SLOTS_PER_ROW;
  localparam int unsigned IDX_W     = $clog2(NUM_SLOTS);
  localparam int unsigned CNT_W     = $clog2(NUM_SLOTS + 1);
  localparam int unsigned STEP_W    = $clog2(BUILD_INTERVAL);

  typedef enum logic {S_COUNT, S_SEARCH} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [STEP_W-1:0]    r_step_cnt;
  logic                 r_trig;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_scan;
  logic [NUM_SLOTS-1:0] r_grid;
  logic [NUM_SLOTS-1:0] w_flood;
  logic [NUM_SLOTS-1:0] w_blocked;
  logic [NUM_SLOTS-1:0] w_set_mask;
  logic                 w_free;
  logic                 w_do_build;
  logic                 w_advance;
  logic                 w_scan_start;
  logic                 r_pulse;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_pop;
  logic                 r_full;
  logic [11:0]          r_pix;
  logic [11:0]          w_pix;

  // Flood mask: L*FLOOD_COLS columns lost from each side, both bands.
  always_comb begin
    int unsigned lvl;
    int unsigned ncut;
    lvl = 32'(bus.flood_level);
    if (lvl > MAX_FLOOD) lvl = MAX_FLOOD;
    ncut = lvl * FLOOD_COLS;
    w_flood = '0;
    for (int unsigned c = 0; c < SLOTS_PER_ROW; c++) begin
      // Written as c + ncut to avoid unsigned underflow when ncut > SLOTS_PER_ROW.
      if ((c < ncut) || (c + ncut >= SLOTS_PER_ROW)) begin
        w_flood[c]                 = 1'b1;
        w_flood[c + SLOTS_PER_ROW] = 1'b1;
      end
    end
  end

`ifdef BLDG_RECLAIM_EN
  assign w_blocked = w_flood;
`else
  logic [NUM_SLOTS-1:0] r_ruined;

  // Sticky ruin record: a slot that has ever been flooded stays blocked.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_ruined <= '0;
    else         r_ruined <= r_ruined | w_flood;
  end

  assign w_blocked = w_flood | r_ruined;
`endif

  assign w_free = ~r_grid[r_ptr] & ~w_blocked[r_ptr];

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_COUNT;
    else         r_state <= w_next_state;
  end

  // FSM next state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_COUNT:  if (r_trig) w_next_state = S_SEARCH;
      S_SEARCH: if (w_free || (r_scan == IDX_W'(NUM_SLOTS - 1))) w_next_state = S_COUNT;
      default:  w_next_state = S_COUNT;
    endcase
  end

  // FSM control outputs; triggers arriving during SEARCH are ignored.
  always_comb begin
    w_scan_start = 1'b0;
    w_advance    = 1'b0;
    w_do_build   = 1'b0;
    case (r_state)
      S_COUNT:  w_scan_start = r_trig;
      S_SEARCH: begin
        w_advance  = 1'b1;
        w_do_build = w_free;
      end
      default: ;
    endcase
  end

  assign w_set_mask = w_do_build ? (NUM_SLOTS'(1) << r_ptr) : '0;

  // Population count and pixel lookup over the current grid.
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) w_pop = w_pop + CNT_W'(r_grid[i]);
  end

  always_comb begin
    logic [10:0]      dx;
    logic [10:0]      col;
    logic [10:0]      dy_top;
    logic [10:0]      dy_bot;
    logic             in_col;
    logic             in_top;
    logic             in_bot;
    logic [IDX_W-1:0] idx;
    dx     = hcount_ext() - 11'(LEFT_EDGE);
    col    = dx / 11'(SLOT_W);
    in_col = (bus.hcount_in >= 11'(LEFT_EDGE)) && (col < 11'(SLOTS_PER_ROW));
    // Wrapped subtraction: rows above the band become large and fail the compare.
    dy_top = {1'b0, bus.vcount_in} - 11'(TOP_ROW_Y);
    dy_bot = {1'b0, bus.vcount_in} - 11'(BOTTOM_ROW_Y);
    in_top = dy_top < 11'(SLOT_H);
    in_bot = dy_bot < 11'(SLOT_H);
    idx    = in_top ? IDX_W'(col) : IDX_W'(col) + IDX_W'(SLOTS_PER_ROW);
    w_pix  = 12'h000;
    if (in_col && (in_top || in_bot) && r_grid[idx]) begin
      // Bottom band swaps the color phase.
      w_pix = ((col[0] == 1'b0) == in_top) ? COLOR_1 : COLOR_2;
    end
  end

  function automatic logic [10:0] hcount_ext();
    return bus.hcount_in;
  endfunction

  // Step counter, search pointer, grid and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_step_cnt <= '0;
      r_trig     <= 1'b0;
      r_ptr      <= '0;
      r_scan     <= '0;
      r_grid     <= '0;
      r_pulse    <= 1'b0;
      r_idx      <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_pix      <= 12'h000;
    end else begin
      r_trig <= 1'b0;
      if (bus.game_step) begin
        if (r_step_cnt == STEP_W'(BUILD_INTERVAL - 1)) begin
          r_step_cnt <= '0;
          r_trig     <= 1'b1;
        end else begin
          r_step_cnt <= r_step_cnt + STEP_W'(1);
        end
      end

      if (w_scan_start)   r_scan <= '0;
      else if (w_advance) r_scan <= r_scan + IDX_W'(1);

      if (w_advance) r_ptr <= (r_ptr == IDX_W'(NUM_SLOTS - 1)) ? '0 : r_ptr + IDX_W'(1);

      // Flood clearing wins over a same-cycle build.
      r_grid  <= (r_grid | w_set_mask) & ~w_flood;
      r_pulse <= w_do_build;
      if (w_do_build) r_idx <= r_ptr;

      r_count <= w_pop;
      r_full  <= &(r_grid | w_blocked);
      r_pix   <= w_pix;
    end
  end

  assign bus.pixel_out   = r_pix;
  assign bus.bldg_count  = r_count;
  assign bus.full        = r_full;
  assign bus.build_pulse = r_pulse;
  assign bus.build_idx   = r_idx;
endmodule

// File: tb/tb_building_grid.sv
// Purpose : directed scoreboard bench for building_grid (default or
//           BLDG_RECLAIM_EN build).
module tb_building_grid;
  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  building_grid_if bus ();

  building_grid dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t it;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed 0x%0h with no expected entry", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        miscompares++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic send_steps(input int n);
    for (int i = 0; i < n; i++) begin
      bus.game_step = 1'b1;
      tick();
    end
    bus.game_step = 1'b0;
  endtask

  task automatic wait_build(input int budget, output bit seen, output int idx);
    seen = 1'b0;
    idx  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.build_pulse === 1'b1) begin
        seen = 1'b1;
        idx  = int'(bus.build_idx);
      end
    end
  endtask

  // One full interval of steps; expects a build at exp_idx.
  task automatic build_one(input string tag, input int exp_idx);
    bit seen;
    int idx;
    push(tag, 32'(exp_idx));
    send_steps(32);
    wait_build(40, seen, idx);
    chk(seen ? 32'(idx) : 32'hFFFF_FFFF);
  endtask

  task automatic pix_at(input string tag, input int h, input int v, input logic [11:0] exp);
    bus.hcount_in = 11'(h);
    bus.vcount_in = 10'(v);
    push(tag, 32'(exp));
    tick();
    chk(32'(bus.pixel_out));
  endtask

  task automatic check_outputs_zero(input string tag);
    push({tag, "_pix"},   32'h0); chk(32'(bus.pixel_out));
    push({tag, "_cnt"},   32'h0); chk(32'(bus.bldg_count));
    push({tag, "_full"},  32'h0); chk(32'(bus.full));
    push({tag, "_pulse"}, 32'h0); chk(32'(bus.build_pulse));
    push({tag, "_idx"},   32'h0); chk(32'(bus.build_idx));
  endtask

  initial begin
    bit seen;
    int idx;
    bit seen0;
    bit ruined_hit;
    int exp_final;

    rst_in          = 1'b0;
    bus.game_step   = 1'b0;
    bus.flood_level = '0;
    bus.hcount_in   = '0;
    bus.vcount_in   = '0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst_in = 1'b1;

    // First build after exactly one interval.
    build_one("first_build", 0);
    bus.hcount_in = 11'd128;
    bus.vcount_in = 10'd0;
    push("first_pix_128_0", 32'h0A52);
    push("first_count", 32'd1);
    tick();
    chk(32'(bus.pixel_out));
    chk(32'(bus.bldg_count));
    pix_at("pix_192_0", 192, 0, 12'h000);
    pix_at("pix_127_0", 127, 0, 12'h000);

    // Round-robin builds through slot 13, then color alternation.
    for (int k = 1; k < 14; k++) build_one($sformatf("build_%0d", k), k);
    push("count_14", 32'd14);
    tick();
    chk(32'(bus.bldg_count));
    pix_at("pix_150_50",  150, 50,  12'hA52);
    pix_at("pix_200_50",  200, 50,  12'h652);
    pix_at("pix_150_700", 150, 700, 12'h652);
    pix_at("pix_200_700", 200, 700, 12'hA52);
    pix_at("pix_128_96",  128, 96,  12'h000);
    pix_at("pix_896_0",   896, 0,   12'h000);

    // Fresh grid, fill every slot.
    #2 rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    for (int k = 0; k < 24; k++) build_one($sformatf("fill_%0d", k), k);
    push("full_count", 32'd24);
    push("full_flag", 32'd1);
    tick();
    chk(32'(bus.bldg_count));
    chk(32'(bus.full));

    // Trigger on a full grid: search gives up without a build.
    push("full_no_build", 32'd0);
    send_steps(32);
    wait_build(30, seen, idx);
    chk(32'(seen));

    // Reset in the middle of a search, between clock edges.
    bus.hcount_in = 11'd128;
    bus.vcount_in = 10'd0;
    send_steps(32);
    for (int i = 0; i < 4; i++) tick();
    #2 rst_in = 1'b0;
    #1;
    check_outputs_zero("midsearch_reset");
    tick();
    tick();
    rst_in = 1'b1;
    push("rst_31_steps_no_build", 32'd0);
    send_steps(31);
    wait_build(40, seen, idx);
    chk(32'(seen));
    send_steps(1);
    push("rst_32nd_step_build", 32'd1);
    wait_build(40, seen, idx);
    chk(32'(seen && idx == 0));

    // Flood level 1 clears columns 0,1,10,11 in both bands.
    for (int k = 1; k < 4; k++) build_one($sformatf("pre_flood_%0d", k), k);
    push("pre_flood_count", 32'd4);
    tick();
    chk(32'(bus.bldg_count));
    bus.flood_level = 2'd1;
    tick();
    tick();
    push("flood_count", 32'd2);
    push("flood_full", 32'd0);
    chk(32'(bus.bldg_count));
    chk(32'(bus.full));
    build_one("post_flood_build", 4);

    // Flood recedes; keep triggering and see what becomes buildable.
    bus.flood_level = 2'd0;
    seen0      = 1'b0;
    ruined_hit = 1'b0;
    for (int t = 0; t < 24; t++) begin
      send_steps(32);
      wait_build(40, seen, idx);
      if (seen && idx == 0) seen0 = 1'b1;
      if (seen && (idx inside {0, 1, 10, 11, 12, 13, 22, 23})) ruined_hit = 1'b1;
    end
    tick();
`ifdef BLDG_RECLAIM_EN
    exp_final = 24;
    push("reclaim_slot0", 32'd1);
    chk(32'(seen0));
`else
    exp_final = 16;
    push("ruined_never_built", 32'd0);
    chk(32'(ruined_hit));
`endif
    push("after_flood_count", 32'(exp_final));
    push("after_flood_full", 32'd1);
    chk(32'(bus.bldg_count));
    chk(32'(bus.full));

    // Max flood: every slot blocked and cleared.
    bus.flood_level = 2'd3;
    tick();
    tick();
    push("max_flood_count", 32'd0);
    push("max_flood_full", 32'd1);
    chk(32'(bus.bldg_count));
    chk(32'(bus.full));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
